cam_stream_tx: RTL and testbench
================================

# cam_stream_tx

Camera-side transmitter for the 8-bit parallel YUV422 camera bus (pclk/href/vsync/cam_data). It accepts RGB332 pixels from an on-chip source, converts each pixel pair to a Y1 U Y2 V byte group, and drives sensor-style frame timing: vsync pulse, back porch, href-framed active lines and front porch. It serves as the sensor model for exercising the camera capture path on hardware and in simulation, and as a video source for downstream consumers of the same bus.

## Interface
- H_ACTIVE, 640: pixels per active line; even, ≥2
- V_ACTIVE, 480: active lines per frame
- H_BLANK, 144: href-low byte cycles after each line; ≥1
- VSYNC_LINES, 3: line periods with vsync high
- V_BACK, 17: line periods after vsync, before the first active line
- V_FRONT, 10: line periods after the last active line
- pclk  in  1  byte clock; all logic on posedge
- rst_n  in  1  synchronous, active-low reset
- enable  in  1  start and continue frames
- pix_data  in  8  RGB332 pixel {r[2:0],g[2:0],b[1:0]}
- pix_valid  in  1  pix_data valid
- pix_ready  out  1  block accepts pix_data this cycle
- vsync  out  1  frame sync, active high
- href  out  1  active byte window
- cam_data  out  8  bus byte
- frame_done  out  1  one-cycle pulse at end of frame
- underrun  out  1  sticky; missing pixels detected

## Operation
- LINE_LEN = 2*H_ACTIVE + H_BLANK cycles per line period. Counters: col 0..LINE_LEN-1, line within state.
- States:
  - IDLE: all outputs low. Go to VSYNC the cycle after enable=1 is sampled.
  - VSYNC: vsync=1 for VSYNC_LINES*LINE_LEN cycles, then V_BACK.
  - V_BACK: V_BACK*LINE_LEN cycles, then ACTIVE.
  - ACTIVE: V_ACTIVE lines. href=1 for col<2*H_ACTIVE, 0 otherwise. Then V_FRONT.
  - V_FRONT: V_FRONT*LINE_LEN cycles. frame_done=1 on its last cycle. Next state is VSYNC if enable=1, else IDLE.
- enable deasserted mid-frame: the current frame completes normally.
- Pixel buffer: 2-entry FIFO. pix_ready = !full, and low in IDLE and reset. Push on pix_valid&pix_ready. Pushes are accepted during blanking so the source can prime.
- Pair pop: in the cycle before each 4-byte group, i.e. active col=4k-1 (k≥1), and the last cycle of the line period preceding each active line.
  - If 2 entries are held: pop both, with pixel0 = older.
  - Otherwise: pop nothing, emit black (Y=16, U=V=128) for that group, set underrun.
  - A push and a pop in the same cycle are both honoured.
- Conversion (pure integer; pixel expanded to 8-bit as R={r,r,r[2:1]}, G={g,g,g[2:1]}, B={b,b,b,b}):
  - Y = 16 + ((66R+129G+25B+128)>>>8)
  - U = 128 + ((-38R-74G+112B+128)>>>8)
  - V = 128 + ((112R-94G-18B+128)>>>8)
  - Signed ≥18-bit intermediates, arithmetic shift, result clamped to 0..255.
  - Y1 and Y2 come from pixel0 and pixel1 respectively; U and V come from pixel0 only.
- Byte order within a group: Y1, U, Y2, V.
- underrun clears only on reset.

## Timing
- All outputs registered. Reset values: vsync=0, href=0, cam_data=0, pix_ready=0, frame_done=0, underrun=0. FIFO flushed, state IDLE.
- Reset mid-frame takes effect at the next edge. The first cycle after rst_n rises is IDLE.
- cam_data = 0 whenever href=0.
- href rises at col 0 with cam_data=Y1 of that line's first pair. The pop for that pair happens 1 cycle earlier.
- Pixel-to-bus latency: a pixel pushed at least 1 cycle before its pop cycle appears on the bus 1 cycle after the pop.
- Sustained source rate: 1 pixel / 2 cycles during href.
- Frame length = (VSYNC_LINES+V_BACK+V_ACTIVE+V_FRONT)*LINE_LEN cycles. Back-to-back frames have no gap.

## Test plan
Parameters for all scenarios: H_ACTIVE=4, V_ACTIVE=2, H_BLANK=4, VSYNC_LINES=1, V_BACK=1, V_FRONT=1 (LINE_LEN=12, frame=60 cycles).
- Reset, then enable=1 -> vsync high for 12 cycles starting 1 cycle after enable. href high for 8 cycles at frame cycles 24 and 36. frame_done pulses at cycle 59. Next vsync at cycle 60.
- Source always valid with 0xFF,0x00 repeating -> each group reads 235,128,16,128.
- Pair (0xE0,0xE0) -> group reads 82,90,82,240.
- Stop pix_valid after 6 pixels -> line 2 second group is 16,128,16,128, underrun=1 and stays high through the next frame.
- enable dropped during ACTIVE -> frame completes, frame_done pulses, then IDLE with all outputs 0.
- rst_n low for 1 cycle mid-line -> next cycle href=0, vsync=0, cam_data=0, underrun=0, FIFO empty, pix_ready=0.

Source files
------------

// File: rtl/cam_stream_tx.sv
// Sensor-style YUV422 byte-bus transmitter: takes RGB332 pixels, emits Y1 U Y2 V groups
// under vsync/href frame timing (vsync, back porch, active lines, front porch).
module cam_stream_tx #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] pix_data,
  input  logic       pix_valid,
  output logic       pix_ready,
  output logic       vsync,
  output logic       href,
  output logic [7:0] cam_data,
  output logic       frame_done,
  output logic       underrun
);

  localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
  localparam int COL_W    = $clog2(LINE_LEN);
  localparam int LM_A     = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
  localparam int LM_B     = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int LMAX     = (LM_A > LM_B) ? LM_A : LM_B;
  localparam int LINE_W   = $clog2(LMAX + 1);

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(LINE_LEN - 1);
  localparam logic [COL_W-1:0] HREF_COLS = COL_W'(2 * H_ACTIVE);
  localparam logic [7:0]       Y_BLACK   = 8'd16;
  localparam logic [7:0]       C_BLACK   = 8'd128;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_VFRONT
  } state_t;

  state_t              state, nxt_state;
  logic [COL_W-1:0]    col, nxt_col;
  logic [LINE_W-1:0]   line, nxt_line, lines_last;

  logic [1:0]          count, nxt_count;
  logic [7:0]          mem0, mem1;
  logic [7:0]          grp_u, grp_y2, grp_v;
  logic                nxt_href, pop_slot, pop, push;

  function automatic int exp_r(input logic [7:0] p);
    return int'({p[7:5], p[7:5], p[7:6]});
  endfunction

  function automatic int exp_g(input logic [7:0] p);
    return int'({p[4:2], p[4:2], p[4:3]});
  endfunction

  function automatic int exp_b(input logic [7:0] p);
    return int'({p[1:0], p[1:0], p[1:0], p[1:0]});
  endfunction

  function automatic logic [7:0] clamp8(input int v);
    if (v < 0)   return '0;
    if (v > 255) return '1;
    return 8'(v);
  endfunction

  function automatic logic [7:0] luma(input logic [7:0] p);
    return clamp8(16 + ((66 * exp_r(p) + 129 * exp_g(p) + 25 * exp_b(p) + 128) >>> 8));
  endfunction

  function automatic logic [7:0] chroma_u(input logic [7:0] p);
    return clamp8(128 + ((-38 * exp_r(p) - 74 * exp_g(p) + 112 * exp_b(p) + 128) >>> 8));
  endfunction

  function automatic logic [7:0] chroma_v(input logic [7:0] p);
    return clamp8(128 + ((112 * exp_r(p) - 94 * exp_g(p) - 18 * exp_b(p) + 128) >>> 8));
  endfunction

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      col   <= '0;
      line  <= '0;
    end else begin
      state <= nxt_state;
      col   <= nxt_col;
      line  <= nxt_line;
    end
  end

  always_comb begin
    lines_last = '0;
    case (state)
      ST_VSYNC:  lines_last = LINE_W'(VSYNC_LINES - 1);
      ST_VBACK:  lines_last = LINE_W'(V_BACK - 1);
      ST_ACTIVE: lines_last = LINE_W'(V_ACTIVE - 1);
      ST_VFRONT: lines_last = LINE_W'(V_FRONT - 1);
      default:   lines_last = '0;
    endcase
  end

  always_comb begin
    nxt_state = state;
    nxt_col   = col;
    nxt_line  = line;
    if (state == ST_IDLE) begin
      nxt_col  = '0;
      nxt_line = '0;
      if (enable) nxt_state = ST_VSYNC;
    end else if (col == COL_LAST) begin
      nxt_col = '0;
      if (line == lines_last) begin
        nxt_line = '0;
        case (state)
          ST_VSYNC:  nxt_state = ST_VBACK;
          ST_VBACK:  nxt_state = ST_ACTIVE;
          ST_ACTIVE: nxt_state = ST_VFRONT;
          ST_VFRONT: nxt_state = enable ? ST_VSYNC : ST_IDLE;
          default:   nxt_state = ST_IDLE;
        endcase
      end else begin
        nxt_line = line + 1'b1;
      end
    end else begin
      nxt_col = col + 1'b1;
    end
  end

  // Outputs are registered from the next-cycle position, so the pair pop lands in the
  // cycle before each group's first byte (including the last cycle of the prior line).
  always_comb begin
    nxt_href  = (nxt_state == ST_ACTIVE) && (nxt_col < HREF_COLS);
    pop_slot  = nxt_href && (nxt_col[1:0] == 2'd0);
    push      = pix_valid && pix_ready;
    pop       = pop_slot && (count == 2'd2);
    nxt_count = count;
    if (pop)  nxt_count = 2'd0;
    if (push) nxt_count = nxt_count + 2'd1;
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      count      <= '0;
      mem0       <= '0;
      mem1       <= '0;
      grp_u      <= '0;
      grp_y2     <= '0;
      grp_v      <= '0;
      cam_data   <= '0;
      href       <= 1'b0;
      vsync      <= 1'b0;
      frame_done <= 1'b0;
      pix_ready  <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      count <= nxt_count;
      if (push) begin
        if (pop || count == 2'd0) mem0 <= pix_data;
        else                      mem1 <= pix_data;
      end
      if (pop_slot) begin
        if (pop) begin
          grp_u  <= chroma_u(mem0);
          grp_y2 <= luma(mem1);
          grp_v  <= chroma_v(mem0);
        end else begin
          grp_u    <= C_BLACK;
          grp_y2   <= Y_BLACK;
          grp_v    <= C_BLACK;
          underrun <= 1'b1;
        end
      end
      cam_data <= '0;
      if (nxt_href) begin
        case (nxt_col[1:0])
          2'd0: cam_data <= pop ? luma(mem0) : Y_BLACK;
          2'd1: cam_data <= grp_u;
          2'd2: cam_data <= grp_y2;
          2'd3: cam_data <= grp_v;
        endcase
      end
      href       <= nxt_href;
      vsync      <= (nxt_state == ST_VSYNC);
      frame_done <= (nxt_state == ST_VFRONT) && (nxt_col == COL_LAST) &&
                    (nxt_line == LINE_W'(V_FRONT - 1));
      pix_ready  <= (nxt_state != ST_IDLE) && (nxt_count != 2'd2);
    end
  end

endmodule

// File: tb/tb_cam_stream_tx.sv
// Randomized bench for cam_stream_tx: frame-position reference model feeds an expected-byte
// queue; a separate monitor compares bus bytes and control outputs every cycle.
module tb_cam_stream_tx;

  localparam int HA = 4, VA = 2, HB = 4, VS = 1, VB = 1, VF = 1;
  localparam int LL    = 2 * HA + HB;
  localparam int FRAME = (VS + VB + VA + VF) * LL;
  localparam int ACT0  = (VS + VB) * LL;

  logic       pclk, rst_n, enable, pix_valid, pix_ready;
  logic [7:0] pix_data, cam_data;
  logic       vsync, href, frame_done, underrun;

  cam_stream_tx #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
    .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
  ) dut (
    .pclk(pclk), .rst_n(rst_n), .enable(enable),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .vsync(vsync), .href(href), .cam_data(cam_data),
    .frame_done(frame_done), .underrun(underrun)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] src_q[$];
  logic [7:0] fifo_m[$];
  logic [7:0] exp_q[$];
  logic [7:0] drop;
  bit         gap_mode = 0;
  bit         hs = 0;
  bit         armed = 0;
  bit         running = 0;
  int         t = 0;
  bit         m_under = 0;
  bit         e_vs, e_hr, e_fd, e_rdy, e_ur;

  initial begin
    pclk = 0;
    forever #5 pclk = ~pclk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (time %0t)", name, got, exp, $time);
  endtask

  function automatic int fdiv256(input int x);
    if (x >= 0) return x / 256;
    return -((-x + 255) / 256);
  endfunction

  function automatic logic [7:0] sat(input int v);
    return 8'((v < 0) ? 0 : (v > 255) ? 255 : v);
  endfunction

  function automatic void expand(input logic [7:0] p, output int r, output int g, output int b);
    int rr, gg;
    rr = int'(p[7:5]);
    gg = int'(p[4:2]);
    r  = 36 * rr + rr / 2;
    g  = 36 * gg + gg / 2;
    b  = 85 * int'(p[1:0]);
  endfunction

  function automatic logic [7:0] ref_y(input logic [7:0] p);
    int r, g, b;
    expand(p, r, g, b);
    return sat(16 + fdiv256(66 * r + 129 * g + 25 * b + 128));
  endfunction

  function automatic logic [7:0] ref_u(input logic [7:0] p);
    int r, g, b;
    expand(p, r, g, b);
    return sat(128 + fdiv256(-38 * r - 74 * g + 112 * b + 128));
  endfunction

  function automatic logic [7:0] ref_v(input logic [7:0] p);
    int r, g, b;
    expand(p, r, g, b);
    return sat(128 + fdiv256(112 * r - 94 * g - 18 * b + 128));
  endfunction

  function automatic bit href_at(input int f);
    return (f >= ACT0) && (f < ACT0 + VA * LL) && (((f - ACT0) % LL) < 2 * HA);
  endfunction

  function automatic bit group_start(input int f);
    return href_at(f) && ((((f - ACT0) % LL) % 4) == 0);
  endfunction

  // Reference model: evaluated just before each rising edge, predicts the following cycle.
  initial begin
    forever begin
      @(negedge pclk);
      #4;
      armed = 1;
      if (!rst_n) begin
        running = 0;
        t = 0;
        fifo_m.delete();
        exp_q.delete();
        m_under = 0;
        hs = 0;
      end else begin
        logic [7:0] p0, p1;
        bit acc;
        acc = pix_valid && pix_ready;
        hs  = acc;
        if (!running) begin
          if (enable) begin
            running = 1;
            t = 0;
          end
        end else begin
          t++;
          if (t == FRAME) begin
            if (enable) t = 0;
            else running = 0;
          end
        end
        if (running && group_start(t)) begin
          if (fifo_m.size() >= 2) begin
            p0 = fifo_m.pop_front();
            p1 = fifo_m.pop_front();
            exp_q.push_back(ref_y(p0));
            exp_q.push_back(ref_u(p0));
            exp_q.push_back(ref_y(p1));
            exp_q.push_back(ref_v(p0));
          end else begin
            exp_q.push_back(8'd16);
            exp_q.push_back(8'd128);
            exp_q.push_back(8'd16);
            exp_q.push_back(8'd128);
            m_under = 1;
          end
        end
        if (acc) fifo_m.push_back(pix_data);
      end
      e_vs  = running && (t < VS * LL);
      e_hr  = running && href_at(t);
      e_fd  = running && (t == FRAME - 1);
      e_rdy = running && (fifo_m.size() < 2);
      e_ur  = m_under;
    end
  end

  // Monitor: control outputs every cycle, one expected byte per href cycle.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge pclk);
      #1;
      if (armed) begin
        chk("ctl{vsync,href,frame_done,pix_ready,underrun}",
            int'({vsync, href, frame_done, pix_ready, underrun}),
            int'({e_vs, e_hr, e_fd, e_rdy, e_ur}));
        if (href) begin
          if (exp_q.size() == 0) begin
            chk("cam_data_unexpected_href_byte", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("cam_data", int'(cam_data), int'(e));
          end
        end else begin
          chk("cam_data_blank", int'(cam_data), 0);
        end
      end
    end
  end

  task automatic tick();
    @(negedge pclk);
    if (hs && src_q.size() > 0) drop = src_q.pop_front();
    if (src_q.size() > 0 && (!gap_mode || $urandom_range(0, 3) != 0)) begin
      pix_valid = 1'b1;
      pix_data  = src_q[0];
    end else begin
      pix_valid = 1'b0;
      pix_data  = 8'($urandom);
    end
  endtask

  task automatic wait_fd(input int budget);
    bit seen = 0;
    for (int n = 0; n < budget && !seen; n++) begin
      tick();
      if (frame_done) seen = 1;
    end
    chk("wait_frame_done", int'(seen), 1);
  endtask

  task automatic wait_href(input int budget);
    bit seen = 0;
    for (int n = 0; n < budget && !seen; n++) begin
      tick();
      if (href) seen = 1;
    end
    chk("wait_href", int'(seen), 1);
  endtask

  initial begin
    rst_n = 0; enable = 0; pix_valid = 0; pix_data = '0;
    repeat (3) tick();
    rst_n = 1;
    repeat (5) tick();

    // Known-value groups, then random data, source always valid.
    for (int i = 0; i < 4; i++) begin
      src_q.push_back(8'hFF);
      src_q.push_back(8'h00);
    end
    src_q.push_back(8'hE0);
    src_q.push_back(8'hE0);
    for (int i = 0; i < 14; i++) src_q.push_back(8'($urandom));
    enable = 1;
    wait_fd(100);
    wait_fd(100);
    wait_href(100);
    enable = 0;
    wait_fd(100);
    repeat (5) tick();

    // Source stops after 6 pixels: last group of the frame goes black, underrun sticks.
    for (int i = 0; i < 6; i++) src_q.push_back(8'($urandom));
    enable = 1;
    wait_fd(100);
    wait_fd(100);
    wait_href(100);
    repeat (2) tick();
    rst_n = 0;
    enable = 0;
    tick();
    rst_n = 1;
    repeat (3) tick();

    // Random pixels with random gaps in pix_valid.
    gap_mode = 1;
    for (int i = 0; i < 24; i++) src_q.push_back(8'($urandom));
    enable = 1;
    wait_fd(100);
    wait_fd(100);
    wait_href(100);
    enable = 0;
    wait_fd(100);
    repeat (4) tick();

    chk("expected_bytes_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
